// File: rtl/decode_pipe_ctrl.sv
// Main control decoder plus ID/EX and EX/MEM pipeline registers of the 5-stage MIPS-subset CPU.
// Data fields pass through bit-exact; unknown opcodes decode to an all-zero bubble.
module decode_pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] ex_alu_result,
  input  logic        ex_zero,
  output logic [1:0]  id_regdst,
  output logic [1:0]  id_memtoreg,
  output logic [1:0]  id_jump,
  output logic        id_regwrite,
  output logic        id_memread,
  output logic        id_memwrite,
  output logic        id_branch,
  output logic [1:0]  ex_regdst,
  output logic [1:0]  ex_memtoreg,
  output logic [1:0]  ex_jump,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_branch,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_instr,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_rd,
  output logic [4:0]  ex_write_reg,
  output logic [1:0]  mem_memtoreg,
  output logic [1:0]  mem_jump,
  output logic        mem_regwrite,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic        mem_branch,
  output logic        mem_zero,
  output logic [31:0] mem_pc,
  output logic [31:0] mem_instr,
  output logic [31:0] mem_alu_result,
  output logic [31:0] mem_rs_data,
  output logic [31:0] mem_rt_data,
  output logic [4:0]  mem_write_reg
);

  logic [5:0] w_op;
  logic [5:0] w_funct;

  assign w_op    = id_instr[31:26];
  assign w_funct = id_instr[5:0];

  always_comb begin
    id_regdst   = 2'd0;
    id_memtoreg = 2'd0;
    id_jump     = 2'd0;
    id_regwrite = 1'b0;
    id_memread  = 1'b0;
    id_memwrite = 1'b0;
    id_branch   = 1'b0;
    case (w_op)
      6'h00: begin
        if (w_funct == 6'h08) begin
          id_jump = 2'd2;
        end else begin
          id_regdst   = 2'd1;
          id_regwrite = 1'b1;
        end
      end
      6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E: id_regwrite = 1'b1;
      6'h23: begin
        id_memread  = 1'b1;
        id_memtoreg = 2'd1;
        id_regwrite = 1'b1;
      end
      6'h2B:        id_memwrite = 1'b1;
      6'h04, 6'h05: id_branch   = 1'b1;
      6'h02:        id_jump     = 2'd1;
      6'h03: begin
        id_jump     = 2'd1;
        id_regdst   = 2'd2;
        id_memtoreg = 2'd2;
        id_regwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // ID/EX stage
  logic [1:0]  r_ex_regdst, r_ex_memtoreg, r_ex_jump;
  logic        r_ex_regwrite, r_ex_memread, r_ex_memwrite, r_ex_branch;
  logic [31:0] r_ex_pc, r_ex_instr, r_ex_rs_data, r_ex_rt_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_regdst   <= 2'd0;
      r_ex_memtoreg <= 2'd0;
      r_ex_jump     <= 2'd0;
      r_ex_regwrite <= 1'b0;
      r_ex_memread  <= 1'b0;
      r_ex_memwrite <= 1'b0;
      r_ex_branch   <= 1'b0;
      r_ex_pc       <= 32'd0;
      r_ex_instr    <= 32'd0;
      r_ex_rs_data  <= 32'd0;
      r_ex_rt_data  <= 32'd0;
    end else begin
      r_ex_regdst   <= id_regdst;
      r_ex_memtoreg <= id_memtoreg;
      r_ex_jump     <= id_jump;
      r_ex_regwrite <= id_regwrite;
      r_ex_memread  <= id_memread;
      r_ex_memwrite <= id_memwrite;
      r_ex_branch   <= id_branch;
      r_ex_pc       <= id_pc;
      r_ex_instr    <= id_instr;
      r_ex_rs_data  <= id_rs_data;
      r_ex_rt_data  <= id_rt_data;
    end
  end

  assign ex_regdst   = r_ex_regdst;
  assign ex_memtoreg = r_ex_memtoreg;
  assign ex_jump     = r_ex_jump;
  assign ex_regwrite = r_ex_regwrite;
  assign ex_memread  = r_ex_memread;
  assign ex_memwrite = r_ex_memwrite;
  assign ex_branch   = r_ex_branch;
  assign ex_pc       = r_ex_pc;
  assign ex_instr    = r_ex_instr;
  assign ex_rs_data  = r_ex_rs_data;
  assign ex_rt_data  = r_ex_rt_data;
  // Register fields come from the latched instruction, so they clear with it on reset.
  assign ex_rs       = r_ex_instr[25:21];
  assign ex_rt       = r_ex_instr[20:16];
  assign ex_rd       = r_ex_instr[15:11];

  always_comb begin
    ex_write_reg = ex_rt;
    case (ex_regdst)
      2'd1:    ex_write_reg = ex_rd;
      2'd2:    ex_write_reg = 5'd31;
      default: ex_write_reg = ex_rt;
    endcase
  end

  // EX/MEM stage
  logic [1:0]  r_mem_memtoreg, r_mem_jump;
  logic        r_mem_regwrite, r_mem_memread, r_mem_memwrite, r_mem_branch, r_mem_zero;
  logic [31:0] r_mem_pc, r_mem_instr, r_mem_alu_result, r_mem_rs_data, r_mem_rt_data;
  logic [4:0]  r_mem_write_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_memtoreg   <= 2'd0;
      r_mem_jump       <= 2'd0;
      r_mem_regwrite   <= 1'b0;
      r_mem_memread    <= 1'b0;
      r_mem_memwrite   <= 1'b0;
      r_mem_branch     <= 1'b0;
      r_mem_zero       <= 1'b0;
      r_mem_pc         <= 32'd0;
      r_mem_instr      <= 32'd0;
      r_mem_alu_result <= 32'd0;
      r_mem_rs_data    <= 32'd0;
      r_mem_rt_data    <= 32'd0;
      r_mem_write_reg  <= 5'd0;
    end else begin
      r_mem_memtoreg   <= ex_memtoreg;
      r_mem_jump       <= ex_jump;
      r_mem_regwrite   <= ex_regwrite;
      r_mem_memread    <= ex_memread;
      r_mem_memwrite   <= ex_memwrite;
      r_mem_branch     <= ex_branch;
      r_mem_zero       <= ex_zero;
      r_mem_pc         <= ex_pc;
      r_mem_instr      <= ex_instr;
      r_mem_alu_result <= ex_alu_result;
      r_mem_rs_data    <= ex_rs_data;
      r_mem_rt_data    <= ex_rt_data;
      r_mem_write_reg  <= ex_write_reg;
    end
  end

  assign mem_memtoreg   = r_mem_memtoreg;
  assign mem_jump       = r_mem_jump;
  assign mem_regwrite   = r_mem_regwrite;
  assign mem_memread    = r_mem_memread;
  assign mem_memwrite   = r_mem_memwrite;
  assign mem_branch     = r_mem_branch;
  assign mem_zero       = r_mem_zero;
  assign mem_pc         = r_mem_pc;
  assign mem_instr      = r_mem_instr;
  assign mem_alu_result = r_mem_alu_result;
  assign mem_rs_data    = r_mem_rs_data;
  assign mem_rt_data    = r_mem_rt_data;
  assign mem_write_reg  = r_mem_write_reg;

endmodule

// File: tb/tb_decode_pipe_ctrl.sv
// Directed bench for decode_pipe_ctrl: decode table, ID/EX and EX/MEM latency, reset behaviour.
module tb_decode_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_instr, id_pc, id_rs_data, id_rt_data, ex_alu_result;
  logic        ex_zero;
  logic [1:0]  id_regdst, id_memtoreg, id_jump;
  logic        id_regwrite, id_memread, id_memwrite, id_branch;
  logic [1:0]  ex_regdst, ex_memtoreg, ex_jump;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_branch;
  logic [31:0] ex_pc, ex_instr, ex_rs_data, ex_rt_data;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_write_reg;
  logic [1:0]  mem_memtoreg, mem_jump;
  logic        mem_regwrite, mem_memread, mem_memwrite, mem_branch, mem_zero;
  logic [31:0] mem_pc, mem_instr, mem_alu_result, mem_rs_data, mem_rt_data;
  logic [4:0]  mem_write_reg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_pipe_ctrl dut (
    .clk(clk), .rst(rst), .id_instr(id_instr), .id_pc(id_pc), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .ex_alu_result(ex_alu_result), .ex_zero(ex_zero),
    .id_regdst(id_regdst), .id_memtoreg(id_memtoreg), .id_jump(id_jump),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_branch(id_branch), .ex_regdst(ex_regdst), .ex_memtoreg(ex_memtoreg),
    .ex_jump(ex_jump), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_branch(ex_branch), .ex_pc(ex_pc), .ex_instr(ex_instr),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_write_reg(ex_write_reg), .mem_memtoreg(mem_memtoreg),
    .mem_jump(mem_jump), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .mem_branch(mem_branch), .mem_zero(mem_zero),
    .mem_pc(mem_pc), .mem_instr(mem_instr), .mem_alu_result(mem_alu_result),
    .mem_rs_data(mem_rs_data), .mem_rt_data(mem_rt_data), .mem_write_reg(mem_write_reg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packs the 7 id_* control outputs as {regdst,memtoreg,jump,regwrite,memread,memwrite,branch}.
  function automatic logic [31:0] id_ctl();
    return {22'd0, id_regdst, id_memtoreg, id_jump, id_regwrite, id_memread, id_memwrite,
            id_branch};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] rs,
                       input logic [31:0] rt);
    id_instr = ins; id_pc = pc; id_rs_data = rs; id_rt_data = rt;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ex_alu_result = 32'hDEAD_BEEF;
    ex_zero = 1'b1;
    drive(32'h0022_1820, 32'h0000_0044, 32'h1111_1111, 32'h2222_2222);
    tick();
    tick();
    chk("rst_ex_regwrite", ex_regwrite, 0);
    chk("rst_ex_regdst", ex_regdst, 0);
    chk("rst_ex_pc", ex_pc, 0);
    chk("rst_ex_instr", ex_instr, 0);
    chk("rst_ex_rs_data", ex_rs_data, 0);
    chk("rst_ex_write_reg", ex_write_reg, 0);
    chk("rst_mem_instr", mem_instr, 0);
    chk("rst_mem_alu", mem_alu_result, 0);
    chk("rst_mem_zero", mem_zero, 0);
    chk("rst_mem_regwrite", mem_regwrite, 0);
    chk("rst_id_decode_live", id_ctl(), 32'b01_00_00_1_0_0_0);

    // add $3,$1,$2
    rst = 1'b0;
    ex_alu_result = 32'h0000_000C;
    ex_zero = 1'b0;
    drive(32'h0022_1820, 32'h10, 32'd5, 32'd7);
    chk("add_id_ctl", id_ctl(), 32'b01_00_00_1_0_0_0);
    tick();
    chk("add_ex_rd", ex_rd, 3);
    chk("add_ex_rs", ex_rs, 1);
    chk("add_ex_rt", ex_rt, 2);
    chk("add_ex_write_reg", ex_write_reg, 3);
    chk("add_ex_pc", ex_pc, 32'h10);
    chk("add_ex_rs_data", ex_rs_data, 5);
    chk("add_ex_regwrite", ex_regwrite, 1);
    chk("add_mem_not_yet", mem_pc, 0);

    // lw $4,8($1)
    drive(32'h8C24_0008, 32'h14, 32'h100, 32'h55);
    chk("lw_id_ctl", id_ctl(), 32'b00_01_00_1_1_0_0);
    tick();
    chk("add_mem_pc", mem_pc, 32'h10);
    chk("add_mem_write_reg", mem_write_reg, 3);
    chk("add_mem_regwrite", mem_regwrite, 1);
    chk("add_mem_alu", mem_alu_result, 32'hC);
    chk("lw_ex_write_reg", ex_write_reg, 4);
    chk("lw_ex_memread", ex_memread, 1);

    // sw
    ex_alu_result = 32'h20;
    drive(32'hAC24_0008, 32'h18, 32'h100, 32'hCAFE);
    chk("sw_id_ctl", id_ctl(), 32'b00_00_00_0_0_1_0);
    tick();
    chk("lw_mem_memread", mem_memread, 1);
    chk("lw_mem_memtoreg", mem_memtoreg, 1);
    chk("lw_mem_write_reg", mem_write_reg, 4);
    chk("lw_mem_alu", mem_alu_result, 32'h20);
    chk("sw_ex_memwrite", ex_memwrite, 1);
    chk("sw_ex_regwrite", ex_regwrite, 0);

    // beq
    ex_alu_result = 32'h108;
    drive(32'h1022_0003, 32'h1C, 32'h9, 32'h9);
    chk("beq_id_ctl", id_ctl(), 32'b00_00_00_0_0_0_1);
    tick();
    chk("sw_mem_memwrite", mem_memwrite, 1);
    chk("sw_mem_regwrite", mem_regwrite, 0);
    chk("sw_mem_rt_data", mem_rt_data, 32'hCAFE);
    chk("sw_mem_rs_data", mem_rs_data, 32'h100);
    chk("beq_ex_branch", ex_branch, 1);

    // jal
    ex_zero = 1'b1;
    drive(32'h0C00_0010, 32'h20, 32'h0, 32'h0);
    chk("jal_id_ctl", id_ctl(), 32'b10_10_01_1_0_0_0);
    tick();
    chk("beq_mem_branch", mem_branch, 1);
    chk("beq_mem_zero", mem_zero, 1);
    chk("beq_mem_pc", mem_pc, 32'h1C);
    chk("jal_ex_write_reg", ex_write_reg, 31);
    chk("jal_ex_memtoreg", ex_memtoreg, 2);
    chk("jal_ex_jump", ex_jump, 1);

    // jr $31
    ex_zero = 1'b0;
    drive(32'h03E0_0008, 32'h24, 32'h28, 32'h0);
    chk("jr_id_ctl", id_ctl(), 32'b00_00_10_0_0_0_0);
    tick();
    chk("jal_mem_jump", mem_jump, 1);
    chk("jal_mem_memtoreg", mem_memtoreg, 2);
    chk("jal_mem_write_reg", mem_write_reg, 31);
    chk("jal_mem_regwrite", mem_regwrite, 1);
    chk("jr_ex_jump", ex_jump, 2);
    chk("jr_ex_regwrite", ex_regwrite, 0);

    // combinational-only decode spot checks
    drive(32'h2001_0005, 32'h0, 32'h0, 32'h0);
    chk("addi_id_ctl", id_ctl(), 32'b00_00_00_1_0_0_0);
    drive(32'h3401_0005, 32'h0, 32'h0, 32'h0);
    chk("ori_id_ctl", id_ctl(), 32'b00_00_00_1_0_0_0);
    drive(32'h1422_0003, 32'h0, 32'h0, 32'h0);
    chk("bne_id_ctl", id_ctl(), 32'b00_00_00_0_0_0_1);
    drive(32'h3C01_1234, 32'h0, 32'h0, 32'h0);
    chk("lui_bubble_id_ctl", id_ctl(), 0);

    // j
    drive(32'h0800_0010, 32'h28, 32'h0, 32'h0);
    chk("j_id_ctl", id_ctl(), 32'b00_00_01_0_0_0_0);
    tick();
    chk("jr_mem_jump", mem_jump, 2);
    chk("j_ex_jump", ex_jump, 1);
    chk("j_ex_regwrite", ex_regwrite, 0);

    // halt word
    drive(32'hFFFF_FFFF, 32'h2C, 32'h0, 32'h0);
    chk("halt_id_ctl", id_ctl(), 0);
    tick();
    chk("halt_ex_instr", ex_instr, 32'hFFFF_FFFF);
    chk("halt_ex_write_reg", ex_write_reg, 5'h1F);
    drive(32'h0022_1820, 32'h30, 32'h1, 32'h2);
    tick();
    chk("halt_mem_instr", mem_instr, 32'hFFFF_FFFF);
    chk("halt_mem_regwrite", mem_regwrite, 0);
    chk("halt_mem_jump", mem_jump, 0);
    chk("add2_ex_regwrite", ex_regwrite, 1);

    // mid-stream reset clears both stages on the same edge
    rst = 1'b1;
    drive(32'h8C24_0008, 32'h34, 32'h3, 32'h4);
    chk("rst_id_still_decodes", id_ctl(), 32'b00_01_00_1_1_0_0);
    tick();
    chk("midrst_ex_instr", ex_instr, 0);
    chk("midrst_ex_regwrite", ex_regwrite, 0);
    chk("midrst_mem_instr", mem_instr, 0);
    chk("midrst_mem_regwrite", mem_regwrite, 0);
    chk("midrst_mem_pc", mem_pc, 0);
    rst = 1'b0;
    tick();
    chk("postrst_ex_instr", ex_instr, 32'h8C24_0008);
    chk("postrst_ex_pc", ex_pc, 32'h34);
    chk("postrst_mem_instr", mem_instr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_pipe_ctrl.md
Name: decode_pipe_ctrl

Overview:
Main control decoder plus the ID/EX and EX/MEM pipeline registers of the 5-stage MIPS-subset CPU.
- Decodes the IF/ID instruction into control signals.
- Latches control, PC, instruction and register operands into the EX stage.
- Selects the destination register in EX.
- Latches EX results into the MEM stage, which feeds memory, the branch/jump calculators and MEM/WB.

Parameters:
None. Fixed: 32-bit data, 5-bit register address, 2-bit multi-way selects.

Ports:
clk  in  1  clock; all registers update on rising edge
rst  in  1  synchronous active-high reset
id_instr  in  32  instruction from IF/ID
id_pc  in  32  PC value from IF/ID, carried unmodified
id_rs_data  in  32  register-file read data for rs
id_rt_data  in  32  register-file read data for rt
ex_alu_result  in  32  ALU result computed from the ex_* outputs
ex_zero  in  1  ALU zero/branch-taken flag
id_regdst, id_memtoreg, id_jump  out  2 each  combinational decode
id_regwrite, id_memread, id_memwrite, id_branch  out  1 each  combinational decode
ex_regdst, ex_memtoreg, ex_jump  out  2 each  ID/EX control
ex_regwrite, ex_memread, ex_memwrite, ex_branch  out  1 each  ID/EX control
ex_pc, ex_instr, ex_rs_data, ex_rt_data  out  32 each  ID/EX data
ex_rs, ex_rt, ex_rd  out  5 each  id_instr[25:21], [20:16], [15:11]
ex_write_reg  out  5  combinational destination select
mem_memtoreg, mem_jump  out  2 each  EX/MEM control
mem_regwrite, mem_memread, mem_memwrite, mem_branch, mem_zero  out  1 each  EX/MEM control/flag
mem_pc, mem_instr, mem_alu_result, mem_rs_data, mem_rt_data  out  32 each  EX/MEM data
mem_write_reg  out  5  EX/MEM destination register

Behaviour:
Decode (combinational, from op = id_instr[31:26], funct = id_instr[5:0]). Default for any signal not listed is 0.
- op 0x00, funct != 0x08 (R-type): regdst=1, regwrite=1, memtoreg=0.
- op 0x00, funct 0x08 (jr): jump=2, regwrite=0.
- op 0x08, 0x09, 0x0C, 0x0D, 0x0E, 0x0A (addi/addiu/andi/ori/xori/slti): regdst=0, regwrite=1.
- op 0x23 (lw): memread=1, memtoreg=1, regwrite=1, regdst=0.
- op 0x2B (sw): memwrite=1.
- op 0x04, 0x05 (beq/bne): branch=1. Taken/not-taken sense comes from ex_zero only.
- op 0x02 (j): jump=1.
- op 0x03 (jal): jump=1, regdst=2, memtoreg=2, regwrite=1.
- Any other op, including the 0xFFFFFFFF halt word: all control 0, i.e. a bubble.

Encodings:
- regdst: 0=rt, 1=rd, 2=$31, 3=treated as rt.
- memtoreg: 0=ALU, 1=memory, 2=PC path.

ID/EX register:
- On rising clk, rst=1: every ex_* register output cleared to 0.
- Otherwise: loads the decode outputs, id_pc, id_instr, rs/rt data and the rs/rt/rd fields.
- Latency 1 cycle. No stall, no flush, always enabled.

Destination select (combinational): ex_write_reg = ex_rt / ex_rd / 5'd31 per ex_regdst.

EX/MEM register:
- On rising clk, rst=1: every mem_* output cleared to 0.
- Otherwise: loads ex_regwrite, ex_memtoreg, ex_jump, ex_branch, ex_memread, ex_memwrite, ex_pc, ex_instr, ex_zero, ex_alu_result, ex_rs_data, ex_rt_data, ex_write_reg.
- Latency 1 cycle. Always enabled.

General:
- Total ID→MEM latency is 2 cycles. No hazard detection or forwarding in this block.
- Reset mid-operation clears both stages on that edge; the decoder output stays combinational.
- Reset has priority over any incoming data.
- No arithmetic is performed; all data fields pass through bit-exact.

Test Plan:
1. Reset: hold rst=1 for 2 edges with nonzero inputs → all ex_* and mem_* = 0. After release, the first instruction appears on ex_* 1 cycle later and on mem_* 2 cycles later.
2. R-type add $3,$1,$2 (0x00221820), id_pc=0x10, id_rs_data=5 → id_regdst=1, id_regwrite=1. Next cycle: ex_rd=3, ex_write_reg=3, ex_pc=0x10, ex_rs_data=5.
3. lw $4,8($1) (0x8C240008), then ex_alu_result=0x20 → after 2 edges: mem_memread=1, mem_memtoreg=1, mem_write_reg=4, mem_alu_result=0x20.
4. sw (0xAC240008): mem_memwrite=1, mem_regwrite=0, mem_rt_data equals id_rt_data from 2 cycles earlier. beq (0x10220003) with ex_zero=1: mem_branch=1, mem_zero=1.
5. jal (0x0C000010) → ex_write_reg=31, memtoreg=2, jump=1. jr $31 (0x03E00008) → jump=2, regwrite=0. j (0x08000010) → jump=1, regwrite=0.
6. Halt 0xFFFFFFFF → all control 0; mem_instr=0xFFFFFFFF after 2 edges. Assert rst between two back-to-back instructions → both stages read 0 on the next edge.
